dmem_byte_reader: RTL
=====================

# dmem_byte_reader

Streaming byte reader for the data memory: given a byte address and a byte count, it fetches words through the memory's combinational read port and emits the bytes one per handshake, in big-endian lane order (byte offset 0 = bits 31:24). It is the read-side counterpart of the byte-store path (`sb`) and sits beside `dmem` as a second master on its read port, feeding peripherals or a load-byte datapath. It also provides the `lb`-style sign-extended value of each byte.

## Interface
- `LEN_W`, default 16: width of the byte-count field; maximum transfer is 2^LEN_W − 1 bytes.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: launch request; sampled only in IDLE.
- `base` in 32: starting byte address; any alignment is legal.
- `len` in LEN_W: number of bytes to read.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of the transfer.
- `mem_a` out 32: word address to the memory read port, always `{addr_q[31:2], 2'b00}`.
- `mem_rd` in 32: combinational read data for `mem_a`.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: the consumer accepts the byte.
- `out_byte` out 8: current byte.
- `out_sext` out 32: `out_byte` sign-extended from bit 7.
- `out_last` out 1: the current byte is the final byte of the transfer.

## Operation
- Registers: `state`, `addr_q` (32), `rem_q` (LEN_W), `word_q` (32).
- IDLE: on `start`, load `addr_q`←`base` and `rem_q`←`len`. If `len`==0, go to DONE; otherwise go to FETCH.
- FETCH: load `word_q`←`mem_rd`, then go to EMIT.
- EMIT:
  - `out_valid`=1.
  - `out_byte` is the lane of `word_q` selected by `addr_q[1:0]`: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
  - `out_last` = (`rem_q`==1).
  - On a handshake (`out_valid`&`out_ready`): `addr_q`+=1 and `rem_q`−=1. Next state is DONE if `rem_q`==1, FETCH if `addr_q[1:0]`==11, otherwise stay in EMIT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- While `busy`, `start` is ignored. It is not queued.
- `out_byte`, `out_sext` and `out_last` are 0 whenever `out_valid`=0.
- Address arithmetic is modulo 2^32: 0xFFFFFFFF+1 wraps to 0. Aliasing outside the physical RAM is the memory's responsibility.
- Coherence: a word is captured only in FETCH. A write to the same word by another master after its FETCH is not reflected in later bytes of that word.
- While `out_ready`=0, every output is held stable.

## Timing
- Reset values: `state`=IDLE; `addr_q`, `rem_q` and `word_q` are 0. All outputs are 0, including `mem_a`=0.
- Reset asserted mid-transfer: the block returns to IDLE immediately, `out_valid` drops asynchronously, and no `done` is issued.
- Start latency: `start` is sampled high at edge N, FETCH occupies cycle N+1, and the first `out_valid` is in cycle N+2.
- Per-word overhead: one FETCH bubble each time the lane offset crosses 11→00. The peak rate is 4 bytes per 5 cycles for an aligned stream with `out_ready` held high.
- `done` is asserted in the cycle after the last handshake.
- With `len`=0, `done` is asserted in the cycle after `start`.
- `start` sampled in the same cycle that DONE→IDLE is taken is ignored, because the state is not IDLE at that edge.

## Structure
- Package `dmem_rd_pkg` holds:
  - the `state_t` enum {IDLE, FETCH, EMIT, DONE};
  - the lane-offset constants;
  - the function `be_lane(word, off)` returning the big-endian byte. Future load-byte/halfword logic shares it.
- No sub-module is needed; the lane mux is the package function. Target size is about 150 lines of RTL.

## Test plan
- Aligned read: memory word 0 = 0x11223344, word 1 = 0x55667788; `base`=0, `len`=5, `out_ready`=1 → bytes 11,22,33,44,55, one FETCH bubble before 55, `out_last` on 55, `done` one cycle later.
- Unaligned and sign extension: word 0 = 0x00A0B0FF; `base`=2, `len`=2 → B0 (`out_sext`=0xFFFFFFB0) then FF (`out_sext`=0xFFFFFFFF). Captures issued: `mem_a`=0 only.
- Backpressure: as the first case, with `out_ready` toggling 1,0,0,1… → outputs stable while not ready, no byte lost or duplicated, same byte order.
- Zero length and busy start: `len`=0 → `done` in cycle N+1 with no `out_valid`. A second `start` during a 4-byte transfer is ignored and only 4 bytes appear.
- Reset mid-transfer: assert `reset` after 2 of 6 bytes → `out_valid`, `busy`, `done` and `mem_a` all 0 immediately. A subsequent transfer from `base`=4 behaves normally.
- Address wrap: `base`=0xFFFFFFFE, `len`=4 → `mem_a` 0xFFFFFFFC then 0x00000000; the bytes come from the last word's lanes 2 and 3, then lanes 0 and 1 of word 0.

Source files
------------

// File: rtl/dmem_rd_pkg.sv
// Shared definitions for the data-memory byte read path.
// This includes the FSM states, the lane offsets and the big-endian lane selector.
package dmem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte offsets within a word; offset 0 is the most significant lane.
    localparam logic [1:0] LANE_0 = 2'b00;
    localparam logic [1:0] LANE_1 = 2'b01;
    localparam logic [1:0] LANE_2 = 2'b10;
    localparam logic [1:0] LANE_3 = 2'b11;

    // Returns the byte at offset 'off' of 'word' in big-endian lane order.
    function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        b = 8'h00;
        unique case (off)
            LANE_0:  b = word[31:24];
            LANE_1:  b = word[23:16];
            LANE_2:  b = word[15:8];
            LANE_3:  b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_byte_reader.sv
// Streaming byte reader: fetches words from the data memory read port and
// emits them one byte per handshake in big-endian order, with sign extension.
module dmem_byte_reader
    import dmem_rd_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_a,
    input  logic [31:0]      mem_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [31:0]      out_sext,
    output logic             out_last
);

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_rem;
    logic [31:0]      r_word;

    logic             w_emit;
    logic             w_last;
    logic [7:0]       w_byte;

    assign w_emit = (r_state == EMIT);
    assign w_last = (r_rem == LEN_W'(1));

    // Transfer FSM: the word is captured only in FETCH, and bytes advance only on a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= 32'h0;
            r_rem   <= '0;
            r_word  <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= base;
                        r_rem   <= len;
                        r_state <= (len == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    r_word  <= mem_rd;
                    r_state <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        r_addr <= r_addr + 32'd1;
                        r_rem  <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end else if (r_addr[1:0] == LANE_3) begin
                            r_state <= FETCH;
                        end else begin
                            r_state <= EMIT;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output decode from registered state; data outputs are forced to zero outside EMIT.
    always_comb begin
        w_byte    = w_emit ? be_lane(r_word, r_addr[1:0]) : 8'h00;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        mem_a     = {r_addr[31:2], 2'b00};
        out_valid = w_emit;
        out_byte  = w_byte;
        out_sext  = {{24{w_byte[7]}}, w_byte};
        out_last  = w_emit & w_last;
    end

endmodule
